act_lut_loader: RTL and testbench

ACT_LUT_LOADER -- requirements
Module: act_lut_loader

---
 rtl/act_lut_loader.sv | 189 ++++++++++++++++++
 tb/tb_act_lut_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_lut_loader.sv
// ---------------------------------------------------------------------------
// act_lut_loader
//
// Streams an activation lookup table over AXI-Stream into the port-B write
// side of a dual-port LUT RAM. Each 32-bit beat carries two 16-bit entries
// (low half -> even address, high half -> odd address) and is written over
// two consecutive cycles, giving one beat per two cycles.
//
// Optional feature macro: ACT_LUT_LOADER_CHKSUM_EN
//   defined   : lut_chksum accumulates the mod-2^16 sum of written entries
//   undefined : lut_chksum is tied to 16'h0000, no accumulator is built
//
// Parameters
//   LUT_ADDR_WIDTH  LUT address width (depth = 2**LUT_ADDR_WIDTH x 16 bit)
//   SIM_DELAY       kept for interface compatibility; RTL is zero-delay
//
// Ports
//   aclk            clock, rising edge
//   areset          asynchronous active-high reset
//   aclken          clock enable; low freezes all state, write enable forced 0
//   load_start      one-cycle request to begin a table load (IDLE only)
//   load_busy       high while receiving/writing beats
//   load_done       one-cycle pulse when the load finishes
//   load_err        sticky framing error (early or missing s_axis_last)
//   lut_rd_blk      mirrors load_busy; blocks LUT readers during a load
//   s_axis_*        AXI-Stream slave carrying table data
//   lut_mem_*_b     LUT RAM write port B
//   lut_chksum      entry checksum (see macro above)
// ---------------------------------------------------------------------------
module act_lut_loader #(
    parameter int LUT_ADDR_WIDTH = 12,
    parameter int SIM_DELAY      = 1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      aclken,
    input  logic                      load_start,
    output logic                      load_busy,
    output logic                      load_done,
    output logic                      load_err,
    output logic                      lut_rd_blk,
    input  logic [31:0]               s_axis_data,
    input  logic                      s_axis_last,
    input  logic                      s_axis_valid,
    output logic                      s_axis_ready,
    output logic                      lut_mem_clk_b,
    output logic                      lut_mem_wen_b,
    output logic [LUT_ADDR_WIDTH-1:0] lut_mem_addr_b,
    output logic [15:0]               lut_mem_din_b,
    output logic [15:0]               lut_chksum
);

    localparam int BEAT_W = LUT_ADDR_WIDTH - 1;

    // SIM_DELAY has no effect on the synthesizable logic.
    if (SIM_DELAY < 0) begin : g_sim_delay_unused
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WR_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [BEAT_W-1:0]         r_beat;
    logic [15:0]               r_hi;
    logic                      r_last;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic                      r_ready;
    logic                      r_wen;
    logic [LUT_ADDR_WIDTH-1:0] r_addr;
    logic [15:0]               r_din;

    logic w_final_beat;
    assign w_final_beat = &r_beat;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_hi    <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else if (aclken) begin
            r_wen  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_state <= RECV;
                        r_beat  <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                RECV: begin
                    // r_ready is always high here, so valid alone accepts.
                    if (s_axis_valid) begin
                        r_state <= WR_HI;
                        r_ready <= 1'b0;
                        r_wen   <= 1'b1;
                        r_addr  <= {r_beat, 1'b0};
                        r_din   <= s_axis_data[15:0];
                        r_hi    <= s_axis_data[31:16];
                        r_last  <= s_axis_last;
                    end
                end
                WR_HI: begin
                    r_wen  <= 1'b1;
                    r_addr <= {r_beat, 1'b1};
                    r_din  <= r_hi;
                    if (r_last || w_final_beat) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        // Error when last arrives early or is missing on the
                        // final beat; a correctly framed table leaves it clear.
                        if (r_last ^ w_final_beat) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_state <= RECV;
                        r_ready <= 1'b1;
                        r_beat  <= r_beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ACT_LUT_LOADER_CHKSUM_EN
    logic        w_start_acc;
    logic        w_lo_wr;
    logic        w_hi_wr;
    logic [15:0] r_chksum;

    assign w_start_acc = aclken && (r_state == IDLE) && load_start;
    assign w_lo_wr     = aclken && (r_state == RECV) && s_axis_valid;
    assign w_hi_wr     = aclken && (r_state == WR_HI);

    // Adds each entry on the edge that registers it onto the write port, so
    // the final odd entry is included by the time load_done is visible.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_chksum <= '0;
        end else if (w_start_acc) begin
            r_chksum <= '0;
        end else if (w_lo_wr) begin
            r_chksum <= r_chksum + s_axis_data[15:0];
        end else if (w_hi_wr) begin
            r_chksum <= r_chksum + r_hi;
        end
    end

    assign lut_chksum = r_chksum;
`else
    assign lut_chksum = '0;
`endif

    // A write held while the enable is low must not repeat on the RAM,
    // which runs on the ungated clock.
    assign lut_mem_wen_b  = r_wen & aclken;
    assign lut_mem_clk_b  = aclk;
    assign lut_mem_addr_b = r_addr;
    assign lut_mem_din_b  = r_din;
    assign load_busy      = r_busy;
    assign lut_rd_blk     = r_busy;
    assign load_done      = r_done;
    assign load_err       = r_err;
    assign s_axis_ready   = r_ready;

endmodule

// File: tb/tb_act_lut_loader.sv
module tb_act_lut_loader;

    localparam int AW     = 12;
    localparam int NBEATS = 1 << (AW - 1);

`ifdef ACT_LUT_LOADER_CHKSUM_EN
    localparam logic [15:0] CHK_ONES = 16'h1000;
`else
    localparam logic [15:0] CHK_ONES = 16'h0000;
`endif

    logic          aclk = 1'b0;
    logic          areset;
    logic          aclken;
    logic          load_start;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic          lut_rd_blk;
    logic [31:0]   s_axis_data;
    logic          s_axis_last;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic          lut_mem_clk_b;
    logic          lut_mem_wen_b;
    logic [AW-1:0] lut_mem_addr_b;
    logic [15:0]   lut_mem_din_b;
    logic [15:0]   lut_chksum;

    always #5 aclk = ~aclk;

    act_lut_loader #(.LUT_ADDR_WIDTH(AW), .SIM_DELAY(1)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .aclken         (aclken),
        .load_start     (load_start),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .load_err       (load_err),
        .lut_rd_blk     (lut_rd_blk),
        .s_axis_data    (s_axis_data),
        .s_axis_last    (s_axis_last),
        .s_axis_valid   (s_axis_valid),
        .s_axis_ready   (s_axis_ready),
        .lut_mem_clk_b  (lut_mem_clk_b),
        .lut_mem_wen_b  (lut_mem_wen_b),
        .lut_mem_addr_b (lut_mem_addr_b),
        .lut_mem_din_b  (lut_mem_din_b),
        .lut_chksum     (lut_chksum)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus table for one load, and the writes observed on port B.
    logic [31:0]   beat_d [NBEATS];
    bit            beat_l [NBEATS];
    logic [AW-1:0] wr_addr_q [$];
    logic [15:0]   wr_din_q  [$];
    int            wr_cyc_q  [$];
    int            cyc       = 0;
    int            done_cnt  = 0;
    int            done_base = 0;
    logic [15:0]   chk_at_done = '0;
    bit            prev_done = 1'b0;
    bit            hs = 1'b0;

    // Monitor samples mid-cycle, away from the rising edge.
    always @(negedge aclk) begin
        cyc++;
        hs = s_axis_valid && s_axis_ready && aclken;
        if (lut_mem_wen_b === 1'b1) begin
            wr_addr_q.push_back(lut_mem_addr_b);
            wr_din_q.push_back(lut_mem_din_b);
            wr_cyc_q.push_back(cyc);
        end
        if (load_done === 1'b1 && !prev_done) begin
            done_cnt++;
            chk_at_done = lut_chksum;
        end
        prev_done = (load_done === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a load ends at the first beat flagged last, or at the final
    // beat of the table, whichever comes first.
    function automatic int model_end();
        for (int i = 0; i < NBEATS; i++) begin
            if (beat_l[i]) return i;
        end
        return NBEATS - 1;
    endfunction

    task automatic drive_load(input bit rnd, input int pause_beat, input int abort_beat,
                              input int start_beat);
        int i;
        int last_i;
        int en_low;
        int guard;
        bit paused;
        i      = 0;
        en_low = 0;
        guard  = 0;
        paused = 1'b0;
        last_i = model_end();
        wr_addr_q.delete();
        wr_din_q.delete();
        wr_cyc_q.delete();
        done_base = done_cnt;
        @(posedge aclk); #1;
        aclken     = 1'b1;
        load_start = 1'b1;
        @(posedge aclk); #1;
        load_start = 1'b0;
        chk("start_busy", load_busy, 1);
        chk("start_err_clear", load_err, 0);
        chk("start_ready", s_axis_ready, 1);
        while (i <= last_i && guard < 30000) begin
            s_axis_data  = beat_d[i];
            s_axis_last  = beat_l[i];
            s_axis_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_start   = (i == start_beat);
            if (en_low > 0) begin
                aclken = 1'b0;
                en_low--;
            end else if (!paused && i == pause_beat) begin
                aclken = 1'b0;
                en_low = 4;
                paused = 1'b1;
            end else begin
                aclken = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            end
            @(posedge aclk); #1;
            guard++;
            if (hs) begin
                if (i == abort_beat) begin
                    areset = 1'b1;
                    #1;
                    chk("abort_wen", lut_mem_wen_b, 0);
                    chk("abort_busy", load_busy, 0);
                    chk("abort_rdblk", lut_rd_blk, 0);
                    s_axis_valid = 1'b0;
                    load_start   = 1'b0;
                    aclken       = 1'b1;
                    repeat (2) @(posedge aclk);
                    #1 areset = 1'b0;
                    repeat (5) @(posedge aclk);
                    #1;
                    chk("abort_write_count", wr_addr_q.size(), 2 * abort_beat);
                    chk("abort_no_done", done_cnt - done_base, 0);
                    return;
                end
                i++;
            end
        end
        chk("drive_timeout", (guard < 30000) ? 1 : 0, 1);
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        load_start   = 1'b0;
        aclken       = 1'b1;
    endtask

    task automatic check_load(input bit contig);
        int          last_i;
        int          n_exp;
        int          n_chk;
        int          w;
        bit          exp_err;
        logic [15:0] sum;
        logic [15:0] exp_din;
        logic [15:0] exp_chk;
        last_i  = model_end();
        n_exp   = 2 * (last_i + 1);
        exp_err = !(last_i == NBEATS - 1 && beat_l[NBEATS - 1]);
        w = 0;
        while (done_cnt == done_base && w < 64) begin
            @(posedge aclk);
            w++;
        end
        repeat (3) @(negedge aclk);
        chk("done_timeout", (w < 64) ? 1 : 0, 1);
        chk("write_count", wr_addr_q.size(), n_exp);
        n_chk = (wr_addr_q.size() < n_exp) ? wr_addr_q.size() : n_exp;
        sum = '0;
        for (int k = 0; k < n_exp; k++) begin
            exp_din = (k % 2 == 0) ? beat_d[k / 2][15:0] : beat_d[k / 2][31:16];
            sum = sum + exp_din;
            if (k < n_chk) begin
                chk("write_addr_din", {16'(wr_addr_q[k]), wr_din_q[k]}, {16'(k), exp_din});
            end
        end
`ifdef ACT_LUT_LOADER_CHKSUM_EN
        exp_chk = sum;
`else
        exp_chk = 16'h0000;
`endif
        chk("done_pulses", done_cnt - done_base, 1);
        chk("load_err", load_err, exp_err);
        chk("busy_after", load_busy, 0);
        chk("chksum_at_done", chk_at_done, exp_chk);
        if (contig && wr_cyc_q.size() == n_exp) begin
            chk("wen_contiguous", wr_cyc_q[n_exp - 1] - wr_cyc_q[0], n_exp - 1);
        end
    endtask

    initial begin
        areset       = 1'b1;
        aclken       = 1'b1;
        load_start   = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_last  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", load_busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_ready", s_axis_ready, 0);
        chk("rst_wen", lut_mem_wen_b, 0);
        chk("rst_addr", lut_mem_addr_b, 0);
        chk("rst_din", lut_mem_din_b, 0);
        chk("rst_chksum", lut_chksum, 0);
        chk("rst_rdblk", lut_rd_blk, 0);
        areset = 1'b0;
        repeat (2) @(posedge aclk);

        // Full ordered table, continuous valid; stray load_start mid-load.
        for (int i = 0; i < NBEATS; i++) begin
            beat_d[i] = {16'(2 * i + 1), 16'(2 * i)};
            beat_l[i] = (i == NBEATS - 1);
        end
        drive_load(1'b0, -1, -1, 500);
        check_load(1'b1);

        // Early last on beat 10, random data and handshake gaps.
        for (int i = 0; i < NBEATS; i++) begin
            beat_d[i] = $urandom;
            beat_l[i] = (i == 10);
        end
        drive_load(1'b1, -1, -1, -1);
        check_load(1'b0);
        repeat (3) @(posedge aclk);
        #1;
        chk("err_sticky", load_err, 1);
        chk("idle_ready", s_axis_ready, 0);

        // Missing last on the final beat.
        for (int i = 0; i < NBEATS; i++) begin
            beat_d[i] = $urandom;
            beat_l[i] = 1'b0;
        end
        drive_load(1'b1, -1, -1, -1);
        check_load(1'b0);

        // Reset after beat 100, then a clean load with an enable pause.
        for (int i = 0; i < NBEATS; i++) begin
            beat_d[i] = $urandom;
            beat_l[i] = (i == NBEATS - 1);
        end
        drive_load(1'b0, -1, 100, -1);
        drive_load(1'b1, 700, -1, -1);
        check_load(1'b0);

        // All-ones table with a 5-cycle enable drop mid-load.
        for (int i = 0; i < NBEATS; i++) begin
            beat_d[i] = 32'h0001_0001;
            beat_l[i] = (i == NBEATS - 1);
        end
        drive_load(1'b0, 1000, -1, -1);
        check_load(1'b0);
        chk("chksum_ones", chk_at_done, CHK_ONES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
